// File: rtl/dot_product_engine.sv
// Streaming dot product over two externally held vectors A and B.
// Fetches one element pair per cycle, accumulates products, then holds the result until it is accepted.
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    output logic                  rd_en_a,
    output logic                  rd_en_b,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] dout_a,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  busy,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  overflow
);

    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Sum is wide enough to expose every bit that carries out of the accumulator.
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   dvalid_q, dvalid_d;

    logic [PROD_W-1:0]      product;
    logic [SUM_W-1:0]       sum;
    logic                   fetching;

    assign product  = PROD_W'(dout_a) * PROD_W'(dout_b);
    assign sum      = SUM_W'(acc_q) + SUM_W'(product);
    assign fetching = (state_q == FETCH);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        dvalid_d = fetching;

        // Read data arrives one cycle after its strobe; dvalid_q tracks that.
        if (dvalid_q) begin
            acc_d = sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | (|sum[SUM_W-1:ACC_WIDTH]);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = (vec_len > DEPTH_L) ? DEPTH_L : vec_len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (len_d == '0) ? HOLD : FETCH;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign rd_en_a      = fetching;
    assign rd_en_b      = fetching;
    assign rd_addr_a    = fetching ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign rd_addr_b    = fetching ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == HOLD);
    assign result       = acc_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: default instance plus a 16-bit accumulator instance,
// both fed by registered memory models and compared with a plain-arithmetic reference.
module tb_dot_product_engine;

    logic clk;
    logic rst_n;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    // instance 0: default parameters
    logic        start0, ready0;
    logic [5:0]  vlen0;
    logic        rd_en_a0, rd_en_b0, busy0, valid0, ovf0;
    logic [4:0]  rd_addr_a0, rd_addr_b0;
    logic [7:0]  dout_a0, dout_b0;
    logic [20:0] res0;

    // instance 1: ACC_WIDTH = 16
    logic        start1, ready1;
    logic [5:0]  vlen1;
    logic        rd_en_a1, rd_en_b1, busy1, valid1, ovf1;
    logic [4:0]  rd_addr_a1, rd_addr_b1;
    logic [7:0]  dout_a1, dout_b1;
    logic [15:0] res1;

    int errors = 0;
    int checks = 0;

    dot_product_engine u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_len(vlen0),
        .rd_en_a(rd_en_a0), .rd_en_b(rd_en_b0), .rd_addr_a(rd_addr_a0), .rd_addr_b(rd_addr_b0),
        .dout_a(dout_a0), .dout_b(dout_b0), .busy(busy0), .result(res0),
        .result_valid(valid0), .result_ready(ready0), .overflow(ovf0)
    );

    dot_product_engine #(.ACC_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_len(vlen1),
        .rd_en_a(rd_en_a1), .rd_en_b(rd_en_b1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
        .dout_a(dout_a1), .dout_b(dout_b1), .busy(busy1), .result(res1),
        .result_valid(valid1), .result_ready(ready1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the sampled strobe.
    always @(posedge clk) begin
        if (rd_en_a0) dout_a0 <= mem_a[rd_addr_a0];
        if (rd_en_b0) dout_b0 <= mem_b[rd_addr_b0];
        if (rd_en_a1) dout_a1 <= mem_a[rd_addr_a1];
        if (rd_en_b1) dout_b1 <= mem_b[rd_addr_b1];
    end

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 8'($urandom_range(0, 255));
            mem_b[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Runs one operation on instance sel and checks reads, latency, result and overflow.
    // hold_cycles > 0 keeps result_ready low in HOLD and pulses start meanwhile.
    task automatic run_op(input int sel, input int vlen, input int hold_cycles, input string name);
        int          n, aw, edges, nreads;
        longint      exact;
        logic [31:0] exp_res, got_res;
        logic        exp_ovf, done;
        logic        v_rda, v_rdb, v_valid, v_ovf, v_busy;
        logic [4:0]  v_aa, v_ab;

        n  = (vlen > 32) ? 32 : vlen;
        aw = (sel != 0) ? 16 : 21;
        exact = 0;
        for (int i = 0; i < n; i++) exact += longint'(mem_a[i]) * longint'(mem_b[i]);
        exp_res = 32'(exact % (longint'(1) << aw));
        exp_ovf = (exact >= (longint'(1) << aw));

        @(negedge clk);
        if (sel != 0) begin start1 = 1'b1; vlen1 = 6'(vlen); ready1 = 1'b0; end
        else          begin start0 = 1'b1; vlen0 = 6'(vlen); ready0 = 1'b0; end
        @(posedge clk);
        edges = 0; nreads = 0; done = 1'b0;
        while (!done && edges < 100) begin
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
            v_rda   = (sel != 0) ? rd_en_a1   : rd_en_a0;
            v_rdb   = (sel != 0) ? rd_en_b1   : rd_en_b0;
            v_aa    = (sel != 0) ? rd_addr_a1 : rd_addr_a0;
            v_ab    = (sel != 0) ? rd_addr_b1 : rd_addr_b0;
            v_valid = (sel != 0) ? valid1     : valid0;
            if (v_rda || v_rdb) begin
                checks++;
                if (v_rda !== 1'b1 || v_rdb !== 1'b1 || v_aa !== 5'(nreads) || v_ab !== 5'(nreads)) begin
                    errors++;
                    $display("FAIL %s read %0d: en_a=%b en_b=%b addr_a=%0d addr_b=%0d, expected both enabled at addr %0d",
                             name, nreads, v_rda, v_rdb, v_aa, v_ab, nreads);
                end
                nreads++;
            end
            if (v_valid === 1'b1) done = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: result_valid not seen within %0d edges", name, edges);
            return;
        end
        checks++;
        if (edges != ((n == 0) ? 0 : n + 1)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, (n == 0) ? 0 : n + 1);
        end
        checks++;
        if (nreads != n) begin
            errors++;
            $display("FAIL %s read count: got %0d, expected %0d", name, nreads, n);
        end
        got_res = (sel != 0) ? 32'(res1) : 32'(res0);
        v_ovf   = (sel != 0) ? ovf1 : ovf0;
        checks++;
        if (got_res !== exp_res || v_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s result: got %0d ovf=%b, expected %0d ovf=%b", name, got_res, v_ovf, exp_res, exp_ovf);
        end

        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            if (sel != 0) start1 = (c == 3); else start0 = (c == 3);
            if (sel != 0) vlen1 = 6'd5; else vlen0 = 6'd5;
            got_res = (sel != 0) ? 32'(res1) : 32'(res0);
            v_valid = (sel != 0) ? valid1 : valid0;
            v_ovf   = (sel != 0) ? ovf1 : ovf0;
            checks++;
            if (v_valid !== 1'b1 || got_res !== exp_res || v_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL %s hold cycle %0d: valid=%b result=%0d ovf=%b, expected valid=1 result=%0d ovf=%b",
                         name, c, v_valid, got_res, v_ovf, exp_res, exp_ovf);
            end
        end

        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        if (sel != 0) ready1 = 1'b1; else ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready0 = 1'b0; ready1 = 1'b0;
        v_valid = (sel != 0) ? valid1 : valid0;
        v_busy  = (sel != 0) ? busy1  : busy0;
        checks++;
        if (v_valid !== 1'b0 || v_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid=%b busy=%b, expected 0 0", name, v_valid, v_busy);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (busy0 !== 1'b0 || rd_en_a0 !== 1'b0 || rd_en_b0 !== 1'b0 || valid0 !== 1'b0 ||
            ovf0 !== 1'b0 || rd_addr_a0 !== 5'd0 || rd_addr_b0 !== 5'd0 || res0 !== 21'd0) begin
            errors++;
            $display("FAIL %s: busy=%b rd_en=%b%b valid=%b ovf=%b addr=%0d/%0d result=%0d, expected all 0",
                     name, busy0, rd_en_a0, rd_en_b0, valid0, ovf0, rd_addr_a0, rd_addr_b0, res0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_low");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("after_reset");
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = (i < 4) ? 8'(i + 1) : 8'($urandom_range(0, 255));
            mem_b[i] = (i < 4) ? 8'(i + 5) : 8'($urandom_range(0, 255));
        end
    endtask

    task automatic test_basic();
        load_basic();
        run_op(0, 4, 0, "basic_len4");
        checks++;
        if (res0 !== 21'd70) begin
            errors++;
            $display("FAIL basic_len4 value: got %0d, expected 70", res0);
        end
    endtask

    task automatic test_full_and_clamp();
        for (int i = 0; i < 32; i++) begin mem_a[i] = 8'hFF; mem_b[i] = 8'hFF; end
        run_op(0, 32, 0, "full_len32");
        checks++;
        if (res0 !== 21'd2080800 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL full_len32 value: got %0d ovf=%b, expected 2080800 ovf=0", res0, ovf0);
        end
        run_op(0, 40, 0, "clamp_len40");
        run_op(0, 63, 0, "clamp_len63");
    endtask

    task automatic test_zero_len();
        fill_random();
        run_op(0, 0, 0, "zero_len");
    endtask

    task automatic test_hold();
        fill_random();
        run_op(0, 7, 10, "hold_len7");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_op(0, $urandom_range(1, 32), 0, "random_b2b");
        end
    endtask

    task automatic test_reset_mid();
        int   waited;
        logic saw_valid;
        fill_random();
        @(negedge clk);
        start0 = 1'b1; vlen0 = 6'd20;
        @(negedge clk);
        start0 = 1'b0;
        waited = 0;
        while (!(rd_en_a0 === 1'b1 && rd_addr_a0 === 5'd10) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 50) begin
            errors++;
            $display("FAIL reset_mid: address 10 never issued");
        end
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (valid0 === 1'b1 || busy0 === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL reset_mid aborted op: saw valid/busy after reset, expected none");
        end
        load_basic();
        run_op(0, 4, 0, "post_reset_len4");
        checks++;
        if (res0 !== 21'd70) begin
            errors++;
            $display("FAIL post_reset_len4 value: got %0d, expected 70", res0);
        end
    endtask

    task automatic test_acc16();
        mem_a[0] = 8'd255; mem_a[1] = 8'd255;
        mem_b[0] = 8'd255; mem_b[1] = 8'd255;
        run_op(1, 2, 0, "acc16_ovf");
        checks++;
        if (res1 !== 16'd64514 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL acc16_ovf value: got %0d ovf=%b, expected 64514 ovf=1", res1, ovf1);
        end
        mem_a[0] = 8'd1; mem_b[0] = 8'd1;
        run_op(1, 1, 0, "acc16_clear");
        checks++;
        if (res1 !== 16'd1 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL acc16_clear value: got %0d ovf=%b, expected 1 ovf=0", res1, ovf1);
        end
        fill_random();
        run_op(1, 32, 0, "acc16_random");
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; ready0 = 1'b0; vlen0 = '0;
        start1 = 1'b0; ready1 = 1'b0; vlen1 = '0;
        fill_random();

        test_reset();
        test_basic();
        test_full_and_clamp();
        test_zero_len();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_acc16();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: element width; unsigned.
REQ-002 SHALL have parameter DEPTH, default 32: maximum vector length; equals vector memory size.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5: vector memory address width.
REQ-004 SHALL have parameter ACC_WIDTH, default 21: accumulator and result width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-006 SHALL have start input 1: request one dot product, sampled in IDLE only.
REQ-007 SHALL have vec_len input ADDR_WIDTH+1: element count, latched on accepted start.
REQ-008 SHALL have rd_en_a/rd_en_b output 1: read strobes to memories A/B.
REQ-009 SHALL have rd_addr_a/rd_addr_b output ADDR_WIDTH: read addresses.
REQ-010 SHALL have dout_a/dout_b input DATA_WIDTH: memory read data, valid one cycle after the edge sampling rd_en.
REQ-011 SHALL have busy output 1: high in any state except IDLE.
REQ-012 SHALL have result output ACC_WIDTH, result_valid output 1, result_ready input 1: valid/ready result handshake.
REQ-013 SHALL have overflow output 1: accumulator carry-out occurred this operation; valid with result.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DRAIN, HOLD.
REQ-015 IDLE + start: latch len = min(vec_len, DEPTH), clear acc, overflow, read counter; go FETCH, or HOLD if len==0.
REQ-016 FETCH: assert rd_en_a and rd_en_b every cycle, rd_addr_a = rd_addr_b = counter 0..len-1 ascending; go DRAIN after issuing address len-1.
REQ-017 SHALL register a data-valid flag one cycle behind each issued read; when set, acc <= acc + dout_a*dout_b.
REQ-018 DRAIN: rd_en low; accumulate final product; go HOLD.
REQ-019 HOLD: result = acc, result_valid = 1; both stable until result_ready high at a clock edge, then go IDLE with result_valid low.
REQ-020 Latency: for len N>=1, result_valid rises on edge N+1 after the edge sampling start; for len 0, on the first edge after.
REQ-021 Product SHALL be full 2*DATA_WIDTH bits, zero-extended into the add; acc wraps modulo 2^ACC_WIDTH.
REQ-022 Any add carrying out of ACC_WIDTH SHALL set overflow, sticky until next accepted start.
REQ-023 start while busy (FETCH, DRAIN, HOLD) SHALL be ignored.
REQ-024 vec_len > DEPTH SHALL be clamped to DEPTH.
REQ-025 result_ready while not in HOLD SHALL be ignored.
REQ-026 Throughput: one element per cycle; no stalls within FETCH.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and busy, rd_en_a, rd_en_b, result_valid, overflow, rd_addr_a, rd_addr_b, result, acc to 0, regardless of state.
REQ-028 Reset mid-operation SHALL discard the partial sum; no result_valid is produced for the aborted operation.
REQ-029 After rst_n deasserts, first accepted start SHALL behave identically to a post-power-up start.

Verification
REQ-030 len=4, A={1,2,3,4}, B={5,6,7,8}, result_ready=1 -> rd_addr 0,1,2,3 on consecutive cycles; result=70 valid 5 edges after start edge; overflow=0.
REQ-031 len=32, all A=B=255 -> result=2080800, overflow=0; vec_len=40 -> same result, 32 reads only.
REQ-032 len=0 -> no rd_en pulses; result=0, result_valid one edge after start.
REQ-033 result_ready low 10 cycles in HOLD, start pulsed meanwhile -> result, result_valid stable, start ignored; ready high -> IDLE, busy=0 next edge.
REQ-034 rst_n low during FETCH at address 10 -> all outputs 0 asynchronously; new start len=4 as REQ-030 -> result=70.
REQ-035 ACC_WIDTH=16, len=2, A=B={255,255} -> result=64514, overflow=1; next operation len=1, A=B=1 -> result=1, overflow=0.
